// File: rtl/dmi_pkg.sv
// rtl/dmi_pkg.sv - shared types for the DMI responder
package dmi_pkg;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        SUCCESS = 2'd0,
        FAILED  = 2'd2
    } dmi_rsp_e;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

endpackage

// File: rtl/shadow_reg.sv
// rtl/shadow_reg.sv - single writable data register with synchronous reset
module shadow_reg #(
    parameter int unsigned      Width      = 32,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [Width-1:0] wr_data,
    output logic [Width-1:0] shadow_out
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_out <= ResetValue;
        end else if (wr_en) begin
            shadow_out <= wr_data;
        end
    end

endmodule

// File: rtl/dmi_responder.sv
// rtl/dmi_responder.sv - DMI request/response target for the abstract data registers
module dmi_responder
    import dmi_pkg::*;
#(
    parameter int unsigned AddrWidth = 7,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumRegs   = 4,
    parameter int unsigned BaseAddr  = 'h04
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [AddrWidth-1:0]           req_addr,
    input  logic [DataWidth-1:0]           req_data,
    input  logic [1:0]                     req_op,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DataWidth-1:0]           rsp_data,
    output logic [1:0]                     rsp_op,
    input  logic [NumRegs-1:0]             hart_wr_en,
    input  logic [DataWidth-1:0]           hart_wr_data,
    output logic [NumRegs*DataWidth-1:0]   data_out
);

    localparam logic [AddrWidth-1:0] BASE_A = AddrWidth'(BaseAddr);
    localparam logic [AddrWidth:0]   NUM_A  = (AddrWidth+1)'(NumRegs);

    state_e                 state_q, state_next;
    logic                   live_q;
    logic                   accept;
    logic                   dmi_wr;
    logic                   in_range;
    logic [AddrWidth-1:0]   addr_off;
    logic [NumRegs-1:0]     sel;
    logic [DataWidth-1:0]   rd_val;
    logic [DataWidth-1:0]   shadow [NumRegs];
    logic [DataWidth-1:0]   rsp_data_q;
    dmi_rsp_e               rsp_op_q;

    // Offset is only meaningful when req_addr >= BASE, so no wrap can alias a hit.
    assign addr_off = req_addr - BASE_A;
    assign in_range = (req_addr >= BASE_A) && ({1'b0, addr_off} < NUM_A);
    assign accept   = req_valid && req_ready;
    assign dmi_wr   = accept && (dmi_op_e'(req_op) == WRITE);

    for (genvar i = 0; i < NumRegs; i++) begin : g_reg
        logic dmi_hit_wr;

        assign sel[i]     = in_range && (addr_off == AddrWidth'(i));
        assign dmi_hit_wr = dmi_wr && sel[i];

        shadow_reg #(
            .Width      (DataWidth),
            .ResetValue ('0)
        ) u_shadow (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en      (dmi_hit_wr || hart_wr_en[i]),
            .wr_data    (dmi_hit_wr ? req_data : hart_wr_data),
            .shadow_out (shadow[i])
        );

        assign data_out[i*DataWidth +: DataWidth] = shadow[i];
    end

    // Read bypass: a hart write landing this cycle is returned instead of the stale value.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NumRegs; i++) begin
            if (sel[i]) begin
                rd_val = hart_wr_en[i] ? hart_wr_data : shadow[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_next;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = live_q;
                if (req_valid && live_q) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
            rsp_op_q   <= SUCCESS;
        end else if (accept) begin
            case (dmi_op_e'(req_op))
                NOP: begin
                    rsp_data_q <= '0;
                    rsp_op_q   <= SUCCESS;
                end
                READ: begin
                    rsp_data_q <= in_range ? rd_val : '0;
                    rsp_op_q   <= in_range ? SUCCESS : FAILED;
                end
                WRITE: begin
                    rsp_data_q <= '0;
                    rsp_op_q   <= in_range ? SUCCESS : FAILED;
                end
                default: begin
                    rsp_data_q <= '0;
                    rsp_op_q   <= FAILED;
                end
            endcase
        end else if (rsp_valid && rsp_ready) begin
            rsp_data_q <= '0;
            rsp_op_q   <= SUCCESS;
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_op   = rsp_op_q;

endmodule

// File: tb/tb_dmi_responder.sv
// tb/tb_dmi_responder.sv - directed self-checking bench for dmi_responder
module tb_dmi_responder;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [6:0]    req_addr;
    logic [31:0]   req_data;
    logic [1:0]    req_op;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic [1:0]    rsp_op;
    logic [3:0]    hart_wr_en;
    logic [31:0]   hart_wr_data;
    logic [127:0]  data_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmi_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_op       (req_op),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_op       (rsp_op),
        .hart_wr_en   (hart_wr_en),
        .hart_wr_data (hart_wr_data),
        .data_out     (data_out)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One request with rsp_ready=1: handshake at next edge, response seen for one cycle.
    task automatic txn(input string tag, input logic [1:0] op, input logic [6:0] addr,
                       input logic [31:0] data, input logic [31:0] exp_data, input logic [1:0] exp_op);
        chk({tag, "_ready"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_data  = data;
        tick();
        req_valid = 1'b0;
        chk({tag, "_rvalid"}, rsp_valid, 1'b1);
        chk({tag, "_rdata"}, rsp_data, exp_data);
        chk({tag, "_rop"}, rsp_op, exp_op);
        tick();
        chk({tag, "_done"}, rsp_valid, 1'b0);
    endtask

    initial begin
        logic [127:0] snap;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_data     = '0;
        req_op       = 2'd0;
        rsp_ready    = 1'b1;
        hart_wr_en   = '0;
        hart_wr_data = '0;
        @(negedge clk);
        tick();
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_data_out", data_out, 128'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", req_ready, 1'b1);

        txn("wr_d1", 2'd2, 7'h05, 32'hDEADBEEF, 32'h0, 2'd0);
        chk("wr_d1_data_out", data_out, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});
        txn("rd_d1", 2'd1, 7'h05, 32'h0, 32'hDEADBEEF, 2'd0);

        txn("rd_miss", 2'd1, 7'h10, 32'h0, 32'h0, 2'd2);
        txn("op3", 2'd3, 7'h04, 32'hFFFF_FFFF, 32'h0, 2'd2);
        txn("wr_miss_hi", 2'd2, 7'h08, 32'h1111_1111, 32'h0, 2'd2);
        txn("wr_miss_lo", 2'd2, 7'h03, 32'h2222_2222, 32'h0, 2'd2);
        txn("nop", 2'd0, 7'h40, 32'h3333_3333, 32'h0, 2'd0);
        chk("miss_unchanged", data_out, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});

        // Bypass: hart write and DMI read of data0 share the handshake cycle
        req_valid = 1'b1; req_op = 2'd1; req_addr = 7'h04;
        hart_wr_en = 4'b0001; hart_wr_data = 32'h1234;
        tick();
        req_valid = 1'b0; hart_wr_en = '0;
        chk("bypass_rdata", rsp_data, 32'h1234);
        chk("bypass_rop", rsp_op, 2'd0);
        chk("bypass_data0", data_out[31:0], 32'h1234);
        tick();

        // DMI write beats hart write on data2
        req_valid = 1'b1; req_op = 2'd2; req_addr = 7'h06; req_data = 32'hAAAA;
        hart_wr_en = 4'b0100; hart_wr_data = 32'h5555;
        tick();
        req_valid = 1'b0; hart_wr_en = '0;
        chk("collide_rop", rsp_op, 2'd0);
        chk("collide_data2", data_out[95:64], 32'hAAAA);
        tick();

        hart_wr_en = 4'b1001; hart_wr_data = 32'h77;
        tick();
        hart_wr_en = '0;
        chk("hart_multi", data_out, {32'h77, 32'hAAAA, 32'hDEADBEEF, 32'h77});

        // Backpressure: response held, next request waits
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_op = 2'd2; req_addr = 7'h07; req_data = 32'h11;
        tick();
        req_op = 2'd1; req_addr = 7'h05; req_data = 32'h0;
        chk("bp_data3", data_out[127:96], 32'h11);
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready_low", req_ready, 1'b0);
            chk("bp_rvalid", rsp_valid, 1'b1);
            chk("bp_rop", rsp_op, 2'd0);
            chk("bp_rdata", rsp_data, 32'h0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_idle_rvalid", rsp_valid, 1'b0);
        chk("bp_idle_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        chk("bp_second_rvalid", rsp_valid, 1'b1);
        chk("bp_second_rdata", rsp_data, 32'hDEADBEEF);
        tick();
        chk("bp_second_done", rsp_valid, 1'b0);

        // Reset while a response is pending
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_op = 2'd1; req_addr = 7'h06;
        tick();
        req_valid = 1'b0;
        chk("rr_pending_rdata", rsp_data, 32'hAAAA);
        snap = data_out;
        chk("rr_regs_before", snap, {32'h11, 32'hAAAA, 32'hDEADBEEF, 32'h77});
        rst_n = 1'b0;
        tick();
        chk("rr_rvalid", rsp_valid, 1'b0);
        chk("rr_data_out", data_out, 128'h0);
        chk("rr_rsp_data", rsp_data, 32'h0);
        chk("rr_ready_in_rst", req_ready, 1'b0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        tick();
        chk("rr_idle_ready", req_ready, 1'b1);
        chk("rr_idle_rvalid", rsp_valid, 1'b0);
        txn("rr_rd_d2", 2'd1, 7'h06, 32'h0, 32'h0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmi_responder.md
# dmi_responder

Debug-module-side target of the DMI link: accepts read/write requests from the debug transport over a valid/ready channel, services them against a bank of `NumRegs` abstract data registers (`data0..`), and returns one response per request over a second valid/ready channel. The hart side can also write the same registers; DMI reads see same-cycle hart writes through the register bypass path. Sits between the DTM-facing DMI bus and the abstract-command logic.

## Interface
- `AddrWidth`, 7, DMI address width
- `DataWidth`, 32, register and data-bus width
- `NumRegs`, 4, number of data registers (1..12)
- `BaseAddr`, 'h04, DMI address of `data0`; `data<i>` is at `BaseAddr+i`
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  responder can accept a request
- `req_addr`  in  AddrWidth  target address
- `req_data`  in  DataWidth  write data
- `req_op`  in  2  0 nop, 1 read, 2 write, 3 reserved
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  transport accepts response
- `rsp_data`  out  DataWidth  read data (0 for non-read or failed)
- `rsp_op`  out  2  0 success, 2 failed
- `hart_wr_en`  in  NumRegs  per-register hart write strobe
- `hart_wr_data`  in  DataWidth  hart write data (shared)
- `data_out`  out  NumRegs*DataWidth  committed register values, `data<i>` at bits [i*DataWidth +: DataWidth]

## Operation
- FSM states: IDLE, RESP. Reset → IDLE.
- IDLE: `req_ready`=1, `rsp_valid`=0. On `req_valid` (handshake), decode and go to RESP.
- RESP: `req_ready`=0, `rsp_valid`=1, `rsp_data`/`rsp_op` stable until `rsp_ready`; on `rsp_ready` → IDLE.
- Hit: `BaseAddr <= req_addr < BaseAddr+NumRegs`, index = `req_addr-BaseAddr` (AddrWidth arithmetic, no wrap past 2^AddrWidth-1).
- Read, hit: `rsp_data` = register value including any hart write in the handshake cycle (bypass); `rsp_op`=0.
- Write, hit: register takes `req_data` at the handshake edge; `rsp_data`=0, `rsp_op`=0.
- Nop (any address): no side effect, `rsp_data`=0, `rsp_op`=0.
- Read/write miss, or op 3 (any address): no side effect, `rsp_data`=0, `rsp_op`=2.
- Hart writes accepted every cycle in any state; multiple strobes write the same data to each selected register.
- DMI write and hart write to the same register in the same cycle: DMI value wins.
- Reset values: all registers 0, `data_out`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_op`=0, `req_ready`=0 while `rst_n`=0, 1 from the first cycle after release.
- Reset in RESP: pending response dropped, state IDLE, registers cleared.

## Timing
- Request handshake at edge N → `rsp_valid` high after edge N; response occupies ≥1 cycle.
- Throughput: one request per 2 cycles at best (no accept while RESP); no back-to-back overlap.
- Write visible on `data_out` after edge N; a read accepted at edge N+2 returns it.
- Hart write at edge M visible on `data_out` after M; a DMI read with handshake in cycle M returns the hart value (bypass), not the old value.
- `rsp_*` registered outputs; `req_ready` decoded from state only, no combinational path from `req_valid` or `rsp_ready`.

## Structure
- `dmi_pkg`: `dmi_op_e` (NOP, READ, WRITE, RSVD), `dmi_rsp_e` (SUCCESS=0, FAILED=2), `state_e` (IDLE, RESP).
- One `shadow_reg` instance per data register (Width=DataWidth, ResetValue=0); write strobe = DMI hit-write OR hart strobe; input mux selects DMI data on DMI hit-write. Read path taps `shadow_out`.
- Response register and FSM in `dmi_responder` itself.

## Test plan
- Reset, then write 'hDEADBEEF to 'h05 (data1), `rsp_ready`=1 → `rsp_op`=0, `rsp_data`=0 one cycle later; `data_out` data1='hDEADBEEF; read 'h05 → 'hDEADBEEF.
- Read 'h10 (miss) and op 3 to 'h04 → `rsp_op`=2, `rsp_data`=0, all registers unchanged.
- Hart writes 'h1234 to data0 in the same cycle as DMI read of 'h04 → `rsp_data`='h1234.
- DMI write 'hAAAA and hart write 'h5555 to data2 same cycle → data2='hAAAA.
- Hold `rsp_ready`=0 5 cycles with `req_valid`=1 → `req_ready`=0, response stable, second request accepted only after response handshake.
- Assert `rst_n`=0 while in RESP → next cycle `rsp_valid`=0, `data_out`=0, IDLE after release.
